// File: rtl/dmem_lsu.sv
// Load/store unit between the EX/MEM stage and a 2 KB big-endian byte-addressed DMEM.
// Optional LSU_MISALIGN_TRAP_EN rejects misaligned half/word accesses; without it only the range check applies.
module dmem_lsu #(
  parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
  parameter int          DM_AW     = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_rdata,
  output logic             resp_err,
  output logic             resp_misalign,
  output logic             dm_cs,
  output logic             dm_r,
  output logic             dm_w,
  output logic [DM_AW-1:0] dm_addr,
  output logic [31:0]      dm_wdata,
  output logic [1:0]       dm_bit_s,
  input  logic [31:0]      dm_rdata
);

  localparam logic [31:0] MEM_BYTES = 32'(1) << DM_AW;

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LBU = 3'd1;
  localparam logic [2:0] OP_LH  = 3'd2;
  localparam logic [2:0] OP_LHU = 3'd3;
  localparam logic [2:0] OP_LW  = 3'd4;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;

  state_t      state;
  logic [2:0]  op_q;
  logic [31:0] off;
  logic [31:0] size;
  logic [1:0]  bit_s;
  logic        is_load;
  logic        range_err;
  logic        misalign;
  logic [31:0] load_ext;

  always_comb begin
    off     = req_addr - BASE_ADDR;
    is_load = (req_op <= OP_LW);
    size    = 32'd4;
    bit_s   = 2'd2;
    case (req_op)
      3'd0, 3'd1, 3'd5: begin size = 32'd1; bit_s = 2'd0; end
      3'd2, 3'd3, 3'd6: begin size = 32'd2; bit_s = 2'd1; end
      default:          begin size = 32'd4; bit_s = 2'd2; end
    endcase
    // Unsigned compare also catches addresses below BASE_ADDR, which wrap to huge offsets.
    range_err = (off > (MEM_BYTES - size));
`ifdef LSU_MISALIGN_TRAP_EN
    misalign = ((bit_s == 2'd1) && req_addr[0]) ||
               ((bit_s == 2'd2) && (req_addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
  end

  // DMEM places the addressed byte in [31:24]; narrower loads are taken from the top.
  always_comb begin
    load_ext = 32'h0;
    case (op_q)
      OP_LB:   load_ext = {{24{dm_rdata[31]}}, dm_rdata[31:24]};
      OP_LBU:  load_ext = {24'h0, dm_rdata[31:24]};
      OP_LH:   load_ext = {{16{dm_rdata[31]}}, dm_rdata[31:16]};
      OP_LHU:  load_ext = {16'h0, dm_rdata[31:16]};
      OP_LW:   load_ext = dm_rdata;
      default: load_ext = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      op_q          <= 3'd0;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_rdata    <= 32'h0;
      resp_err      <= 1'b0;
      resp_misalign <= 1'b0;
      dm_cs         <= 1'b0;
      dm_r          <= 1'b0;
      dm_w          <= 1'b0;
      dm_addr       <= '0;
      dm_wdata      <= 32'h0;
      dm_bit_s      <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q      <= req_op;
            req_ready <= 1'b0;
            if (misalign || range_err) begin
              state         <= ERR;
              resp_valid    <= 1'b1;
              resp_err      <= 1'b1;
              resp_misalign <= misalign;
              resp_rdata    <= 32'h0;
            end else begin
              state    <= ACCESS;
              dm_cs    <= 1'b1;
              dm_r     <= is_load;
              dm_w     <= ~is_load;
              dm_addr  <= off[DM_AW-1:0];
              dm_bit_s <= bit_s;
              dm_wdata <= is_load ? 32'h0 : req_wdata;
            end
          end
        end
        ACCESS: begin
          state         <= RESP;
          resp_valid    <= 1'b1;
          resp_err      <= 1'b0;
          resp_misalign <= 1'b0;
          resp_rdata    <= load_ext;
          dm_cs         <= 1'b0;
          dm_r          <= 1'b0;
          dm_w          <= 1'b0;
          dm_addr       <= '0;
          dm_wdata      <= 32'h0;
          dm_bit_s      <= 2'd0;
        end
        RESP, ERR: begin
          if (resp_ready) begin
            state         <= IDLE;
            req_ready     <= 1'b1;
            resp_valid    <= 1'b0;
            resp_err      <= 1'b0;
            resp_misalign <= 1'b0;
            resp_rdata    <= 32'h0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a behavioural big-endian DMEM that writes on the falling edge.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        resp_misalign;
  logic        dm_cs;
  logic        dm_r;
  logic        dm_w;
  logic [10:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [1:0]  dm_bit_s;
  logic [31:0] dm_rdata;

  int checks = 0;
  int errors = 0;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  localparam logic [2:0] LB = 3'd0, LBU = 3'd1, LH = 3'd2, LHU = 3'd3, LW = 3'd4;
  localparam logic [2:0] SB = 3'd5, SH = 3'd6, SW = 3'd7;

  always #5 clk = ~clk;

  dmem_lsu dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .resp_misalign(resp_misalign),
    .dm_cs(dm_cs), .dm_r(dm_r), .dm_w(dm_w), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_bit_s(dm_bit_s), .dm_rdata(dm_rdata)
  );

  // DMEM model: byte at offset lives in [31:24]; store data is right-aligned.
  logic [7:0]  mem [0:2047] = '{default: 8'h00};
  logic [10:0] a1, a2, a3;
  assign a1 = dm_addr + 11'd1;
  assign a2 = dm_addr + 11'd2;
  assign a3 = dm_addr + 11'd3;

  always_comb begin
    dm_rdata = 32'h0;
    if (dm_cs && dm_r) dm_rdata = {mem[dm_addr], mem[a1], mem[a2], mem[a3]};
  end

  int          cs_cnt = 0;
  logic [10:0] last_addr;
  logic [1:0]  last_bit_s;
  logic        last_w, last_r;

  always @(negedge clk) begin
    if (dm_cs === 1'b1) begin
      cs_cnt++;
      last_addr  = dm_addr;
      last_bit_s = dm_bit_s;
      last_w     = dm_w;
      last_r     = dm_r;
      if (dm_w) begin
        case (dm_bit_s)
          2'd0: mem[dm_addr] = dm_wdata[7:0];
          2'd1: begin mem[dm_addr] = dm_wdata[15:8]; mem[a1] = dm_wdata[7:0]; end
          default: begin
            mem[dm_addr] = dm_wdata[31:24]; mem[a1] = dm_wdata[23:16];
            mem[a2]      = dm_wdata[15:8];  mem[a3] = dm_wdata[7:0];
          end
        endcase
      end
    end
  end

  // Issue one request and drain its response; lat counts posedges from accept to resp_valid.
  task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output logic mis,
                        output int lat);
    int n;
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 1;
    while (resp_valid !== 1'b1 && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    lat = n;
    if (resp_valid !== 1'b1) begin
      checks++; errors++;
      $display("FAIL resp_timeout addr=%h: resp_valid=%b, required 1 within 8 cycles", addr, resp_valid);
    end
    rdata = resp_rdata; err = resp_err; mis = resp_misalign;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b1; req_op = SW; req_addr = 32'h1001_0000;
    req_wdata = 32'h1111_1111; resp_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    checks++; if ({dm_cs, dm_r, dm_w} !== 3'b000) begin errors++; $display("FAIL reset_dm_ctl got=%b exp=000", {dm_cs, dm_r, dm_w}); end
    checks++; if ({resp_rdata, resp_err, resp_misalign} !== 34'h0) begin errors++; $display("FAIL reset_resp got=%h exp=0", {resp_rdata, resp_err, resp_misalign}); end
    checks++; if (cs_cnt !== 0) begin errors++; $display("FAIL reset_no_access got=%0d exp=0", cs_cnt); end
    req_valid = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_word;
    logic [31:0] rd; logic e, m; int lat;
    do_req(SW, 32'h1001_0004, 32'hDEAD_BEEF, rd, e, m, lat);
    checks++; if ({last_addr, last_bit_s, last_w, last_r} !== {11'd4, 2'd2, 1'b1, 1'b0})
      begin errors++; $display("FAIL sw_access addr=%0d bit_s=%0d w=%b r=%b exp 4/2/1/0", last_addr, last_bit_s, last_w, last_r); end
    checks++; if ({e, rd} !== 33'h0) begin errors++; $display("FAIL sw_resp err=%b rdata=%h exp 0/0", e, rd); end
    do_req(LW, 32'h1001_0004, 32'h0, rd, e, m, lat);
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_data got=%h exp=deadbeef", rd); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL lw_latency got=%0d exp=2", lat); end
    checks++; if (last_r !== 1'b1 || last_w !== 1'b0) begin errors++; $display("FAIL lw_ctl r=%b w=%b exp 1/0", last_r, last_w); end
  endtask

  task automatic test_byte;
    logic [31:0] rd; logic e, m; int lat;
    do_req(SB, 32'h1001_0010, 32'h0000_0080, rd, e, m, lat);
    checks++; if (last_bit_s !== 2'd0) begin errors++; $display("FAIL sb_bit_s got=%0d exp=0", last_bit_s); end
    do_req(LB, 32'h1001_0010, 32'h0, rd, e, m, lat);
    checks++; if (rd !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_sext got=%h exp=ffffff80", rd); end
    do_req(LBU, 32'h1001_0010, 32'h0, rd, e, m, lat);
    checks++; if (rd !== 32'h0000_0080) begin errors++; $display("FAIL lbu_zext got=%h exp=00000080", rd); end
    do_req(LW, 32'h1001_0010, 32'h0, rd, e, m, lat);
    checks++; if (rd !== 32'h8000_0000) begin errors++; $display("FAIL sb_placement got=%h exp=80000000", rd); end
  endtask

  task automatic test_half;
    logic [31:0] rd; logic e, m; int lat;
    do_req(SH, 32'h1001_0020, 32'h0000_8001, rd, e, m, lat);
    checks++; if (last_bit_s !== 2'd1) begin errors++; $display("FAIL sh_bit_s got=%0d exp=1", last_bit_s); end
    do_req(LH, 32'h1001_0020, 32'h0, rd, e, m, lat);
    checks++; if (rd !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_sext got=%h exp=ffff8001", rd); end
    do_req(LHU, 32'h1001_0020, 32'h0, rd, e, m, lat);
    checks++; if (rd !== 32'h0000_8001) begin errors++; $display("FAIL lhu_zext got=%h exp=00008001", rd); end
    do_req(LB, 32'h1001_0021, 32'h0, rd, e, m, lat);
    checks++; if (rd !== 32'h0000_0001) begin errors++; $display("FAIL lb_odd_byte got=%h exp=00000001", rd); end
  endtask

  task automatic test_bounds;
    logic [31:0] rd; logic e, m; int lat, c0;
    logic [2:0]  ops  [5] = '{LW, LH, LB, LB, LW};
    logic [31:0] adrs [5] = '{32'h1001_07FE, 32'h1001_07FF, 32'h1000_FFFF, 32'h1001_0800, 32'hFFFF_FFFC};
    logic        mexp [5] = '{TRAP, TRAP, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      c0 = cs_cnt;
      do_req(ops[i], adrs[i], 32'h5555_5555, rd, e, m, lat);
      checks++; if ({e, m} !== {1'b1, mexp[i]}) begin errors++; $display("FAIL bound_err[%0d] err=%b mis=%b exp 1/%b", i, e, m, mexp[i]); end
      checks++; if (rd !== 32'h0 || lat !== 1) begin errors++; $display("FAIL bound_resp[%0d] rdata=%h lat=%0d exp 0/1", i, rd, lat); end
      checks++; if (cs_cnt !== c0) begin errors++; $display("FAIL bound_no_cs[%0d] accesses=%0d exp=0", i, cs_cnt - c0); end
    end
    do_req(SW, 32'h1001_07FC, 32'h1234_5678, rd, e, m, lat);
    do_req(LW, 32'h1001_07FC, 32'h0, rd, e, m, lat);
    checks++; if ({e, rd} !== {1'b0, 32'h1234_5678}) begin errors++; $display("FAIL last_word err=%b rdata=%h exp 0/12345678", e, rd); end
    // Word at offset 5 spans bytes AD BE EF 00 written earlier.
    c0 = cs_cnt;
    do_req(LW, 32'h1001_0005, 32'h0, rd, e, m, lat);
    if (TRAP) begin
      checks++; if ({e, m, cs_cnt - c0} !== {1'b1, 1'b1, 32'd0}) begin errors++; $display("FAIL misaligned_lw err=%b mis=%b cs=%0d exp 1/1/0", e, m, cs_cnt - c0); end
    end else begin
      checks++; if ({e, m, rd} !== {1'b0, 1'b0, 32'hADBE_EF00}) begin errors++; $display("FAIL misaligned_lw err=%b mis=%b rdata=%h exp 0/0/adbeef00", e, m, rd); end
    end
  endtask

  task automatic test_backpressure;
    req_valid = 1'b1; req_op = LW; req_addr = 32'h1001_0004;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      checks++; if ({resp_valid, resp_rdata, req_ready} !== {1'b1, 32'hDEAD_BEEF, 1'b0})
        begin errors++; $display("FAIL bp_hold[%0d] valid=%b rdata=%h req_ready=%b exp 1/deadbeef/0", i, resp_valid, resp_rdata, req_ready); end
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    checks++; if ({resp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL bp_release valid=%b req_ready=%b exp 0/1", resp_valid, req_ready); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd; logic e, m; int lat;
    req_valid = 1'b1; req_op = SW; req_addr = 32'h1001_0040; req_wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if (dm_w !== 1'b1) begin errors++; $display("FAIL rst_sw_in_access dm_w=%b exp=1", dm_w); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if ({dm_cs, dm_w, resp_valid, req_ready} !== 4'b0001) begin errors++; $display("FAIL rst_access_state cs=%b w=%b valid=%b ready=%b exp 0/0/0/1", dm_cs, dm_w, resp_valid, req_ready); end
    do_req(LW, 32'h1001_0040, 32'h0, rd, e, m, lat);
    checks++; if (rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL rst_store_committed got=%h exp=cafef00d", rd); end
    req_valid = 1'b1; req_op = LW; req_addr = 32'h1001_0040;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL rst_resp_pending valid=%b exp=1", resp_valid); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if ({resp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL rst_in_resp valid=%b ready=%b exp 0/1", resp_valid, req_ready); end
  endtask

  task automatic test_back_to_back;
    int t0;
    // Accept-to-accept with immediate resp_ready should be exactly 3 cycles.
    resp_ready = 1'b1; req_valid = 1'b1; req_op = LW; req_addr = 32'h1001_0004;
    @(posedge clk); #1;
    t0 = 1;
    while (req_ready !== 1'b1 && t0 < 10) begin @(posedge clk); #1; t0++; end
    @(posedge clk); #1;
    req_valid = 1'b0; resp_ready = 1'b0;
    checks++; if (t0 !== 3) begin errors++; $display("FAIL throughput cycles=%0d exp=3", t0); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_bounds();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation exceeded 200000 time units");
    $fatal(1);
  end

endmodule
